// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, controller
// states and the opcode-dependent settle time lookup.
package alu_ctrl_pkg;

    localparam logic [2:0] ALUOP_FWD   = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b001;
    localparam logic [2:0] ALUOP_AND   = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_MUL   = 3'b100;
    localparam logic [2:0] ALUOP_SHIFT = 3'b101;
    localparam logic [2:0] ALUOP_SRA   = 3'b110;
    localparam logic [2:0] ALUOP_ROR   = 3'b111;

    localparam int unsigned SETTLE_FAST_DEFAULT = 1;
    localparam int unsigned SETTLE_SLOW_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } ctrl_state_t;

    // Adders and the multiplier have the long carry chains; every other
    // opcode settles in the fast time. Every code maps to a defined value.
    function automatic int unsigned settle_cycles(input logic [2:0] select,
                                                  input int unsigned fast,
                                                  input int unsigned slow);
        case (select)
            ALUOP_ADD, ALUOP_MUL:                       return slow;
            ALUOP_FWD, ALUOP_AND, ALUOP_OR,
            ALUOP_SHIFT, ALUOP_SRA, ALUOP_ROR:          return fast;
            default:                                    return fast;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Purely combinational; the caller owns the
// last-granted pointer so it decides when a grant actually counts.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. The winner's operands
// are registered onto the ALU, held for the opcode's settle time, and the
// result is returned over a valid/ready response channel.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SETTLE_FAST = SETTLE_FAST_DEFAULT,
    parameter int unsigned SETTLE_SLOW = SETTLE_SLOW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data1,
    input  logic [WIDTH-1:0] req0_data2,
    input  logic [2:0]       req0_select,
    input  logic             req0_shift_direction,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data1,
    input  logic [WIDTH-1:0] req1_data2,
    input  logic [2:0]       req1_select,
    input  logic             req1_shift_direction,

    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [2:0]       alu_select,
    output logic             alu_shift_direction,
    input  logic [WIDTH-1:0] alu_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    localparam int CNT_W = 8;

    ctrl_state_t      state_q;
    ctrl_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;

    logic [1:0]       grant;
    logic             winner;
    logic             req_handshake;
    logic             rsp_handshake;

    logic [WIDTH-1:0] win_data1;
    logic [WIDTH-1:0] win_data2;
    logic [2:0]       win_select;
    logic             win_shift_direction;
    logic [CNT_W-1:0] win_cnt_load;

    rr_arbiter2 u_arbiter (
        .valid ({req1_valid, req0_valid}),
        .last  (last_q),
        .grant (grant)
    );

    // Grants are only offered while idle and out of reset; the loser sees READY low.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (reset_n && (state_q == IDLE)) begin
            req0_ready = grant[0];
            req1_ready = grant[1];
        end
    end

    assign winner        = grant[1];
    assign req_handshake = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign rsp_handshake = rsp_valid && rsp_ready;

    // Route the winning requester's payload toward the ALU operand registers.
    always_comb begin
        win_data1           = req0_data1;
        win_data2           = req0_data2;
        win_select          = req0_select;
        win_shift_direction = req0_shift_direction;
        if (winner) begin
            win_data1           = req1_data1;
            win_data2           = req1_data2;
            win_select          = req1_select;
            win_shift_direction = req1_shift_direction;
        end
        win_cnt_load = CNT_W'(settle_cycles(win_select, SETTLE_FAST, SETTLE_SLOW) - 1);
    end

    // Controller state register; reset aborts whatever is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant in IDLE, count down in SETTLE, wait for the consumer in RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_handshake) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand, counter, fairness pointer and response registers. LAST resets
    // to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q               <= '0;
            last_q              <= 1'b1;
            alu_data1           <= '0;
            alu_data2           <= '0;
            alu_select          <= ALUOP_FWD;
            alu_shift_direction <= 1'b0;
            rsp_valid           <= 1'b0;
            rsp_id              <= 1'b0;
            rsp_result          <= '0;
            rsp_zero            <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_handshake) begin
                        alu_data1           <= win_data1;
                        alu_data2           <= win_data2;
                        alu_select          <= win_select;
                        alu_shift_direction <= win_shift_direction;
                        last_q              <= winner;
                        rsp_id              <= winner;
                        cnt_q               <= win_cnt_load;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= (alu_result == '0);
                        rsp_valid  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_handshake) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU model.
module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       req0_valid, req0_ready, req0_shift_direction;
    logic [7:0] req0_data1, req0_data2;
    logic [2:0] req0_select;
    logic       req1_valid, req1_ready, req1_shift_direction;
    logic [7:0] req1_data1, req1_data2;
    logic [2:0] req1_select;
    logic [7:0] alu_data1, alu_data2, alu_result;
    logic [2:0] alu_select;
    logic       alu_shift_direction;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [7:0] rsp_result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       id;
        logic [2:0] sel;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       dir;
        logic [7:0] exp_res;
        logic       exp_zero;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    alu_arbiter dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .req0_valid           (req0_valid),
        .req0_ready           (req0_ready),
        .req0_data1           (req0_data1),
        .req0_data2           (req0_data2),
        .req0_select          (req0_select),
        .req0_shift_direction (req0_shift_direction),
        .req1_valid           (req1_valid),
        .req1_ready           (req1_ready),
        .req1_data1           (req1_data1),
        .req1_data2           (req1_data2),
        .req1_select          (req1_select),
        .req1_shift_direction (req1_shift_direction),
        .alu_data1            (alu_data1),
        .alu_data2            (alu_data2),
        .alu_select           (alu_select),
        .alu_shift_direction  (alu_shift_direction),
        .alu_result           (alu_result),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_id               (rsp_id),
        .rsp_result           (rsp_result),
        .rsp_zero             (rsp_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model of the shared combinational ALU.
    always_comb begin
        logic [15:0] rot;
        rot        = {alu_data1, alu_data1} >> alu_data2[2:0];
        alu_result = alu_data1;
        case (alu_select)
            ALUOP_FWD:   alu_result = alu_data1;
            ALUOP_ADD:   alu_result = alu_data1 + alu_data2;
            ALUOP_AND:   alu_result = alu_data1 & alu_data2;
            ALUOP_OR:    alu_result = alu_data1 | alu_data2;
            ALUOP_MUL:   alu_result = alu_data1 * alu_data2;
            ALUOP_SHIFT: alu_result = alu_shift_direction ? (alu_data1 >> alu_data2)
                                                          : (alu_data1 << alu_data2);
            ALUOP_SRA:   alu_result = 8'($signed(alu_data1) >>> alu_data2);
            ALUOP_ROR:   alu_result = rot[7:0];
            default:     alu_result = alu_data1;
        endcase
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic setReq(input logic id, input logic v, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [2:0] sel, input logic dir);
        if (id) begin
            req1_valid = v; req1_data1 = d1; req1_data2 = d2;
            req1_select = sel; req1_shift_direction = dir;
        end else begin
            req0_valid = v; req0_data1 = d1; req0_data2 = d2;
            req0_select = sel; req0_shift_direction = dir;
        end
    endtask

    // Called just after the handshake edge; counts edges until RSP_VALID.
    task automatic waitResponse(input string tag, input int lat, input logic [7:0] res,
                                input logic zero, input logic id);
        int edges = 0;
        while (rsp_valid !== 1'b1 && edges < 10) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({tag, ".latency"}, edges, lat);
        checkOutput({tag, ".result"}, rsp_result, res);
        checkOutput({tag, ".zero"}, rsp_zero, zero);
        checkOutput({tag, ".id"}, rsp_id, id);
    endtask

    task automatic retireResponse(input string tag);
        @(posedge clk); #1;
        checkOutput({tag, ".retire"}, rsp_valid, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        setReq(v.id, 1'b1, v.d1, v.d2, v.sel, v.dir);
        #1;
        checkOutput({tag, ".grant"}, v.id ? req1_ready : req0_ready, 1'b1);
        @(posedge clk); #1;
        setReq(v.id, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        checkOutput({tag, ".alu_select"}, alu_select, v.sel);
        checkOutput({tag, ".alu_data1"}, alu_data1, v.d1);
        waitResponse(tag, v.lat, v.exp_res, v.exp_zero, v.id);
        retireResponse(tag);
    endtask

    initial begin
        vecs[0]  = '{1'b0, ALUOP_ADD,   8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 2};
        vecs[1]  = '{1'b1, ALUOP_SHIFT, 8'h81, 8'h01, 1'b0, 8'h02, 1'b0, 1};
        vecs[2]  = '{1'b0, ALUOP_ADD,   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 2};
        vecs[3]  = '{1'b0, ALUOP_MUL,   8'h07, 8'h09, 1'b0, 8'h3F, 1'b0, 2};
        vecs[4]  = '{1'b1, ALUOP_MUL,   8'h10, 8'h10, 1'b0, 8'h00, 1'b1, 2};
        vecs[5]  = '{1'b0, ALUOP_FWD,   8'hA5, 8'h00, 1'b0, 8'hA5, 1'b0, 1};
        vecs[6]  = '{1'b1, ALUOP_SHIFT, 8'h81, 8'h01, 1'b1, 8'h40, 1'b0, 1};
        vecs[7]  = '{1'b0, ALUOP_SRA,   8'h80, 8'h02, 1'b0, 8'hE0, 1'b0, 1};
        vecs[8]  = '{1'b1, ALUOP_ROR,   8'h01, 8'h01, 1'b0, 8'h80, 1'b0, 1};
        vecs[9]  = '{1'b0, ALUOP_OR,    8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1};
        vecs[10] = '{1'b1, ALUOP_AND,   8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1};

        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        setReq(1'b0, 1'b1, 8'h00, 8'h00, 3'b000, 1'b0);
        setReq(1'b1, 1'b1, 8'h00, 8'h00, 3'b000, 1'b0);
        #12;
        checkOutput("reset.req0_ready", req0_ready, 1'b0);
        checkOutput("reset.req1_ready", req1_ready, 1'b0);
        checkOutput("reset.rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset.alu_select", alu_select, 3'b000);
        checkOutput("reset.alu_data1", alu_data1, 8'h00);
        checkOutput("reset.rsp_result", rsp_result, 8'h00);
        checkOutput("reset.rsp_id", rsp_id, 1'b0);
        setReq(1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        setReq(1'b1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("[TB] contention sequence");
        setReq(1'b0, 1'b1, 8'h0F, 8'hF0, ALUOP_AND, 1'b0);
        setReq(1'b1, 1'b1, 8'h0F, 8'hF0, ALUOP_OR, 1'b0);
        #1;
        checkOutput("cont.req0_ready", req0_ready, 1'b1);
        checkOutput("cont.req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        setReq(1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        checkOutput("cont.settle_req1_ready", req1_ready, 1'b0);
        waitResponse("cont.a", 1, 8'h00, 1'b1, 1'b0);
        checkOutput("cont.resp_req1_ready", req1_ready, 1'b0);
        retireResponse("cont.a");
        checkOutput("cont.req1_grant", req1_ready, 1'b1);
        @(posedge clk); #1;
        setReq(1'b1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        waitResponse("cont.b", 1, 8'hFF, 1'b0, 1'b1);
        retireResponse("cont.b");
        setReq(1'b0, 1'b1, 8'h33, 8'h00, ALUOP_FWD, 1'b0);
        setReq(1'b1, 1'b1, 8'h44, 8'h00, ALUOP_FWD, 1'b0);
        #1;
        checkOutput("cont2.req0_ready", req0_ready, 1'b1);
        checkOutput("cont2.req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        setReq(1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        waitResponse("cont2.a", 1, 8'h33, 1'b0, 1'b0);
        retireResponse("cont2.a");
        checkOutput("cont2.req1_grant", req1_ready, 1'b1);
        @(posedge clk); #1;
        setReq(1'b1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        waitResponse("cont2.b", 1, 8'h44, 1'b0, 1'b1);
        retireResponse("cont2.b");

        $display("[TB] back-pressure sequence");
        rsp_ready = 1'b0;
        setReq(1'b0, 1'b1, 8'h12, 8'h34, ALUOP_ADD, 1'b0);
        #1;
        @(posedge clk); #1;
        setReq(1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        waitResponse("bp", 2, 8'h46, 1'b0, 1'b0);
        setReq(1'b0, 1'b1, 8'h01, 8'h00, ALUOP_FWD, 1'b0);
        setReq(1'b1, 1'b1, 8'h02, 8'h00, ALUOP_FWD, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("bp.hold%0d.valid", c), rsp_valid, 1'b1);
            checkOutput($sformatf("bp.hold%0d.result", c), rsp_result, 8'h46);
            checkOutput($sformatf("bp.hold%0d.id", c), rsp_id, 1'b0);
            checkOutput($sformatf("bp.hold%0d.ready", c), {req1_ready, req0_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp.retire", rsp_valid, 1'b0);
        checkOutput("bp.req1_wins", {req1_ready, req0_ready}, 2'b10);
        setReq(1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        setReq(1'b1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);

        $display("[TB] reset mid-operation sequence");
        setReq(1'b0, 1'b1, 8'h01, 8'h01, ALUOP_ADD, 1'b0);
        #1;
        @(posedge clk); #1;
        checkOutput("rst.alu_select_before", alu_select, ALUOP_ADD);
        setReq(1'b0, 1'b1, 8'h11, 8'h00, ALUOP_FWD, 1'b0);
        setReq(1'b1, 1'b1, 8'h22, 8'h00, ALUOP_FWD, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("rst.rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst.alu_select", alu_select, 3'b000);
        checkOutput("rst.ready", {req1_ready, req0_ready}, 2'b00);
        @(posedge clk); #1;
        checkOutput("rst.no_response", rsp_valid, 1'b0);
        #2;
        reset_n = 1'b1;
        #1;
        checkOutput("rst.req0_first", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1;
        setReq(1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        waitResponse("rst.a", 1, 8'h11, 1'b0, 1'b0);
        retireResponse("rst.a");
        checkOutput("rst.req1_next", req1_ready, 1'b1);
        @(posedge clk); #1;
        setReq(1'b1, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        waitResponse("rst.b", 1, 8'h22, 1'b0, 1'b1);
        retireResponse("rst.b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
